// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier.
// Define MONT_EXIT_CONV_EN to append a multiply-by-one that leaves the Montgomery domain.
module montgomery_exp_ctrl #(
  parameter int unsigned N   = 512,
  parameter int unsigned ELW = 10
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_r,
  input  logic [N-1:0]   in_e,
  input  logic [ELW-1:0] in_elen,
  input  logic [N-1:0]   in_m,
  output logic           mul_start,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  output logic [N-1:0]   mul_m,
  input  logic [N-1:0]   mul_result,
  input  logic           mul_done,
  output logic [N-1:0]   result,
  output logic           done,
  output logic           busy
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [ELW-1:0] ElenMax = ELW'(N);

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StSqIss,
    StSqWait,
    StMlIss,
    StMlWait,
    StStep,
    StCvIss,
    StCvWait,
    StFinish
  } state_e;

  state_e         state_q;
  logic [N-1:0]   x_q;
  logic [N-1:0]   e_q;
  logic [N-1:0]   acc_q;
  logic [ELW-1:0] elen_q;
  logic [IW-1:0]  idx_q;

  logic [ELW-1:0] elen_clamped;
  logic           last_bit;

  assign elen_clamped = (in_elen > ElenMax) ? ElenMax : in_elen;
  // LOAD tests for an empty exponent; STEP tests whether the bit just processed was bit 0.
  assign last_bit = (state_q == StLoad) ? (elen_q == '0) : (idx_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      x_q       <= '0;
      e_q       <= '0;
      acc_q     <= '0;
      elen_q    <= '0;
      idx_q     <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_m     <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= in_x;
            e_q     <= in_e;
            mul_m   <= in_m;
            elen_q  <= elen_clamped;
            acc_q   <= in_r;
            idx_q   <= IW'(elen_clamped - ELW'(1));
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end

        // Outputs are registered, so each ISS state is entered with its operands and
        // mul_start already set up on the transition edge.
        StLoad, StStep: begin
          if (last_bit) begin
`ifdef MONT_EXIT_CONV_EN
            mul_a     <= acc_q;
            mul_b     <= N'(1);
            mul_start <= 1'b1;
            state_q   <= StCvIss;
`else
            result    <= acc_q;
            done      <= 1'b1;
            state_q   <= StFinish;
`endif
          end else begin
            if (state_q == StStep) idx_q <= idx_q - IW'(1);
            mul_a     <= acc_q;
            mul_b     <= acc_q;
            mul_start <= 1'b1;
            state_q   <= StSqIss;
          end
        end

        StSqIss: state_q <= StSqWait;

        StSqWait: begin
          if (mul_done) begin
            acc_q <= mul_result;
            if (e_q[idx_q]) begin
              mul_a     <= mul_result;
              mul_b     <= x_q;
              mul_start <= 1'b1;
              state_q   <= StMlIss;
            end else begin
              state_q <= StStep;
            end
          end
        end

        StMlIss: state_q <= StMlWait;

        StMlWait: begin
          if (mul_done) begin
            acc_q   <= mul_result;
            state_q <= StStep;
          end
        end

        StCvIss: state_q <= StCvWait;

        StCvWait: begin
          if (mul_done) begin
            acc_q   <= mul_result;
            result  <= mul_result;
            done    <= 1'b1;
            state_q <= StFinish;
          end
        end

        StFinish: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Scoreboard bench for montgomery_exp_ctrl with a behavioural 20-cycle Montgomery multiplier.
module tb_montgomery_exp_ctrl;

  localparam int unsigned N   = 512;
  localparam int unsigned ELW = 10;
  localparam int unsigned Lat = 20;

  typedef logic [N-1:0]   word_t;
  typedef logic [2*N+1:0] wide_t;
  typedef struct {
    word_t       res;
    int unsigned cnt;
  } exp_t;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  word_t          in_x = '0, in_r = '0, in_e = '0, in_m = '0;
  logic [ELW-1:0] in_elen = '0;
  logic           mul_start, mul_done;
  word_t          mul_a, mul_b, mul_m, mul_result, result;
  logic           done, busy;

  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  int unsigned sb_pulses = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  montgomery_exp_ctrl #(.N(N), .ELW(ELW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_x       (in_x),
    .in_r       (in_r),
    .in_e       (in_e),
    .in_elen    (in_elen),
    .in_m       (in_m),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_m      (mul_m),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .result     (result),
    .done       (done),
    .busy       (busy)
  );

  task automatic check(input string name, input wide_t act, input wide_t req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < N / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  function automatic word_t rand_mod();
    word_t w;
    w = rand_word();
    w[0] = 1'b1;
    w[N-1] = 1'b1;
    return w;
  endfunction

  function automatic word_t modmul(input word_t a, input word_t b, input word_t m);
    wide_t p;
    p = (wide_t'(a) * wide_t'(b)) % wide_t'(m);
    return p[N-1:0];
  endfunction

  function automatic word_t r_mod(input word_t m);
    wide_t r;
    r = (wide_t'(1) << N) % wide_t'(m);
    return r[N-1:0];
  endfunction

  // a*b*2^-N mod m by halving with odd-modulus correction.
  function automatic word_t mont(input word_t a, input word_t b, input word_t m);
    wide_t t;
    t = wide_t'(a) * wide_t'(b);
    for (int i = 0; i < N; i++) begin
      if (t[0]) t = t + wide_t'(m);
      t = t >> 1;
    end
    if (t >= wide_t'(m)) t = t - wide_t'(m);
    return t[N-1:0];
  endfunction

  // Plain-domain x^e mod m over the low n exponent bits, right-to-left.
  function automatic word_t modexp(input word_t x, input word_t e, input int unsigned n,
                                   input word_t m);
    word_t one, res, base;
    one  = 1;
    res  = modmul(one, one, m);
    base = x;
    for (int unsigned i = 0; i < n; i++) begin
      if (e[i]) res = modmul(res, base, m);
      base = modmul(base, base, m);
    end
    return res;
  endfunction

  // Multiplier model shared with the DUT reset.
  initial begin
    word_t       cap_a, cap_b, cap_m;
    int unsigned mm_cnt;
    logic        mm_stable, last_start;
    mul_done = 1'b0;
    mul_result = '0;
    mm_cnt = 0;
    mm_stable = 1'b1;
    last_start = 1'b0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (!resetn) begin
        mm_cnt = 0;
        last_start = 1'b0;
      end else begin
        if (mm_cnt > 0) begin
          if (mul_a !== cap_a || mul_b !== cap_b || mul_m !== cap_m) mm_stable = 1'b0;
          mm_cnt--;
          if (mm_cnt == 0) begin
            mul_result = mont(cap_a, cap_b, cap_m);
            mul_done = 1'b1;
            check("operands_stable", mm_stable, 1);
          end
        end
        if (mul_start) begin
          if (last_start || mm_cnt != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL mul_start_spacing: start while busy=%0d, pending=%0d", last_start,
                     mm_cnt);
          end
          cap_a = mul_a;
          cap_b = mul_b;
          cap_m = mul_m;
          mm_cnt = Lat;
          mm_stable = 1'b1;
        end
        last_start = mul_start;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic prev_done;
    exp_t ex;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb_pulses = 0;
        prev_done = 1'b0;
      end else begin
        if (mul_start) sb_pulses++;
        if (prev_done) check("done_width", done, 0);
        if (done) begin
          check("busy_in_done", busy, 1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_done: result %0h with nothing outstanding", result);
          end else begin
            ex = exp_q.pop_front();
            check("result", result, ex.res);
            check("mul_count", sb_pulses, ex.cnt);
          end
          sb_pulses = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic pulse_reset();
    resetn = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic scramble_inputs();
    in_x = rand_word();
    in_r = rand_word();
    in_e = rand_word();
    in_m = rand_word();
    in_elen = ELW'($urandom);
  endtask

  task automatic do_run(input word_t xp, input word_t e, input int unsigned elen,
                        input word_t m, input bit hold);
    exp_t        ex;
    word_t       rm, p;
    int unsigned eff, pop, cyc, budget;
    eff = (elen > N) ? N : elen;
    pop = 0;
    for (int unsigned i = 0; i < eff; i++) pop += e[i];
    rm = r_mod(m);
    p  = modexp(xp, e, eff, m);
`ifdef MONT_EXIT_CONV_EN
    ex.res = p;
    ex.cnt = eff + pop + 1;
`else
    ex.res = modmul(p, rm, m);
    ex.cnt = eff + pop;
`endif
    exp_q.push_back(ex);
    @(negedge clk);
    in_x = modmul(xp, rm, m);
    in_r = rm;
    in_e = e;
    in_elen = ELW'(elen);
    in_m = m;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    scramble_inputs();
    budget = (ex.cnt + 2) * (Lat + 4) + 20;
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL run_timeout: no done after %0d cycles, required within %0d", cyc, budget);
      exp_q.delete();
      pulse_reset();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_run();
    word_t       m;
    int unsigned cyc;
    m = rand_mod();
    @(negedge clk);
    in_x = rand_word() % m;
    in_r = r_mod(m);
    in_e = rand_word();
    in_elen = ELW'(8);
    in_m = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sb_pulses < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("second_mul_start_seen", sb_pulses, 2);
    resetn = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("reset_no_done", done, 0);
      check("reset_no_mul_start", mul_start, 0);
    end
    resetn = 1'b1;
    check("reset_busy_low", busy, 0);
    repeat (3) @(negedge clk);
    check("post_reset_busy_low", busy, 0);
  endtask

  initial begin
    word_t m, xp, ones;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_result", result, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_m", mul_m, 0);
    resetn = 1'b1;
    @(negedge clk);

    do_run(word_t'(3), word_t'(5), 3, word_t'(13), 1'b0);

    m = rand_mod();
    xp = rand_word() % m;
    do_run(xp, word_t'(11), 4, m, 1'b0);
    do_run(xp, rand_word(), 0, m, 1'b0);

    reset_mid_run();
    do_run(rand_word() % m, rand_word(), 12, m, 1'b0);

    do_run(rand_word() % m, rand_word(), 16, m, 1'b1);

    m = rand_mod();
    do_run(rand_word() % m, rand_word(), 600, m, 1'b0);

    ones = '1;
    do_run(rand_word() % m, ones, N, m, 1'b0);

    for (int k = 0; k < 6; k++) begin
      m = rand_mod();
      do_run(rand_word() % m, rand_word(), $urandom_range(1, 48), m, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
